// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter.
//   state_t  - arbiter FSM states (IDLE, ISSUE, WAIT, DONE)
//   grant_t  - owner of the current transaction (loader, video, CPU)
//   TIMEOUT_DEFAULT - default cycle budget for mem_ready in WAIT
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_LDR = 2'd0,
        G_VID = 2'd1,
        G_CPU = 2'd2
    } grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_arbiter_pick.sv
// arb_pick: grant selection for the memory arbiter.
//   clk_sys, RESET     - clock, synchronous active-low reset
//   ldr_req, vid_req,
//   cpu_req            - pending requests
//   take               - the FSM latches the current grant this cycle
//   any                - at least one request pending
//   grant              - selected requester (grant_t encoding)
// Loader always wins. Video and CPU alternate: vid_first marks which of
// the two is preferred on a tie and flips toward the one not just served.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic       ldr_req,
    input  logic       vid_req,
    input  logic       cpu_req,
    input  logic       take,
    output logic       any,
    output logic [1:0] grant
);

    logic   vid_first;
    grant_t g;

    always_comb begin
        g = G_LDR;
        if (ldr_req)
            g = G_LDR;
        else if (vid_req && cpu_req)
            g = vid_first ? G_VID : G_CPU;
        else if (vid_req)
            g = G_VID;
        else if (cpu_req)
            g = G_CPU;
    end

    assign grant = g;
    assign any   = ldr_req | vid_req | cpu_req;

    // Loader grants leave the video/CPU pointer untouched.
    always_ff @(posedge clk_sys) begin
        if (!RESET)
            vid_first <= 1'b1;
        else if (take && !ldr_req && (vid_req || cpu_req))
            vid_first <= (g == G_CPU);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: three-way arbiter (loader, video, CPU) onto a single
// byte-wide memory port with handshake and timeout.
//   clk_sys, RESET                 - clock, synchronous active-low reset
//   ldr_req/ldr_addr/ldr_data      - loader write request; ldr_ack pulse
//   cpu_req/cpu_we/cpu_addr/cpu_din- CPU request; cpu_dout data, cpu_ack pulse
//   vid_req/vid_addr               - video read request; vid_dout, vid_ack pulse
//   mem_addr/mem_din/mem_rd/mem_we - memory command (strobes one cycle)
//   mem_dout/mem_ready             - memory read data and completion
//   err                            - sticky timeout flag, cleared by reset
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_data,
    output logic              ldr_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_dout,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic              mem_we,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              err
);

    localparam logic [3:0] TO_CNT = 4'(TIMEOUT);

    state_t     state;
    grant_t     gnt;
    grant_t     pick_g;
    logic [1:0] pick_grant;
    logic       pick_any;
    logic       is_wr;
    logic [3:0] cnt;
    logic [7:0] rd_val;

    arb_pick u_pick (
        .clk_sys (clk_sys),
        .RESET   (RESET),
        .ldr_req (ldr_req),
        .vid_req (vid_req),
        .cpu_req (cpu_req),
        .take    (state == IDLE),
        .any     (pick_any),
        .grant   (pick_grant)
    );

    assign pick_g = grant_t'(pick_grant);
    // A timed-out read returns all ones.
    assign rd_val = mem_ready ? mem_dout : 8'hFF;

    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            state    <= IDLE;
            gnt      <= G_LDR;
            is_wr    <= 1'b0;
            cnt      <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
            ldr_ack  <= 1'b0;
            cpu_ack  <= 1'b0;
            vid_ack  <= 1'b0;
            cpu_dout <= '0;
            vid_dout <= '0;
            err      <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            mem_we  <= 1'b0;
            ldr_ack <= 1'b0;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            case (state)
                IDLE: begin
                    // Strobes are registered here so they are high during ISSUE.
                    if (pick_any) begin
                        gnt   <= pick_g;
                        state <= ISSUE;
                        case (pick_g)
                            G_LDR: begin
                                mem_addr <= ldr_addr;
                                mem_din  <= ldr_data;
                                is_wr    <= 1'b1;
                                mem_we   <= 1'b1;
                            end
                            G_VID: begin
                                mem_addr <= vid_addr;
                                mem_din  <= '0;
                                is_wr    <= 1'b0;
                                mem_rd   <= 1'b1;
                            end
                            G_CPU: begin
                                mem_addr <= cpu_addr;
                                mem_din  <= cpu_din;
                                is_wr    <= cpu_we;
                                mem_we   <= cpu_we;
                                mem_rd   <= !cpu_we;
                            end
                            default: ;
                        endcase
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // Acks are registered here so they are high during DONE.
                    if (mem_ready || cnt == TO_CNT) begin
                        if (!is_wr) begin
                            if (gnt == G_VID) vid_dout <= rd_val;
                            if (gnt == G_CPU) cpu_dout <= rd_val;
                        end
                        if (!mem_ready) err <= 1'b1;
                        case (gnt)
                            G_LDR:   ldr_ack <= 1'b1;
                            G_VID:   vid_ack <= 1'b1;
                            G_CPU:   cpu_ack <= 1'b1;
                            default: ;
                        endcase
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk_sys = 1'b0;
    logic        RESET;
    logic        ldr_req, cpu_req, cpu_we, vid_req;
    logic [15:0] ldr_addr, cpu_addr, vid_addr;
    logic [7:0]  ldr_data, cpu_din;
    logic        ldr_ack, cpu_ack, vid_ack;
    logic [7:0]  cpu_dout, vid_dout;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_rd, mem_we, mem_ready, err;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .ldr_req   (ldr_req),
        .ldr_addr  (ldr_addr),
        .ldr_data  (ldr_data),
        .ldr_ack   (ldr_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_dout  (cpu_dout),
        .cpu_ack   (cpu_ack),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_dout  (vid_dout),
        .vid_ack   (vid_ack),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in an IDLE cycle with the request already driven.
    // Ends in the DONE cycle after checking the ack pattern {ldr,vid,cpu}.
    task automatic txn(input string tag, input logic [15:0] ea, input logic ewr,
                       input logic [7:0] ed, input logic [7:0] rdata, input logic [2:0] eack);
        tick();
        chk({tag, "_strobe"}, {30'd0, mem_rd, mem_we}, ewr ? 32'd1 : 32'd2);
        chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, ea});
        if (ewr) chk({tag, "_din"}, {24'd0, mem_din}, {24'd0, ed});
        tick();
        chk({tag, "_wait"}, {28'd0, mem_rd, ldr_ack, vid_ack, cpu_ack}, 32'd0);
        mem_ready = 1'b1;
        mem_dout  = rdata;
        tick();
        chk({tag, "_ack"}, {29'd0, ldr_ack, vid_ack, cpu_ack}, {29'd0, eack});
        chk({tag, "_addr_hold"}, {16'd0, mem_addr}, {16'd0, ea});
        mem_ready = 1'b0;
        mem_dout  = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0;
        ldr_req = 0; cpu_req = 0; cpu_we = 0; vid_req = 0;
        ldr_addr = '0; cpu_addr = '0; vid_addr = '0;
        ldr_data = '0; cpu_din = '0;
        mem_dout = '0; mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_strobes", {26'd0, mem_rd, mem_we, ldr_ack, vid_ack, cpu_ack, err}, 32'd0);
        chk("rst_addr", {8'd0, mem_addr, mem_din}, 32'd0);
        chk("rst_dout", {16'd0, cpu_dout, vid_dout}, 32'd0);
        RESET = 1'b1;
        tick();

        // CPU read, minimum latency
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000;
        txn("cpu_rd", 16'h9000, 1'b0, 8'h00, 8'hA5, 3'b001);
        chk("cpu_rd_dout", {24'd0, cpu_dout}, 32'h0000_00A5);
        cpu_req = 0;
        tick();
        chk("cpu_rd_idle", {28'd0, mem_rd, ldr_ack, vid_ack, cpu_ack}, 32'd0);

        // Round-robin from reset: video first, then alternate
        RESET = 1'b0; tick(); RESET = 1'b1; tick();
        vid_req = 1; vid_addr = 16'h9000;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234;
        txn("rr1_vid", 16'h9000, 1'b0, 8'h00, 8'h11, 3'b010);
        chk("rr1_vdout", {24'd0, vid_dout}, 32'h11);
        tick();
        txn("rr2_cpu", 16'h1234, 1'b0, 8'h00, 8'h22, 3'b001);
        chk("rr2_cdout", {24'd0, cpu_dout}, 32'h22);
        tick();
        txn("rr3_vid", 16'h9000, 1'b0, 8'h00, 8'h33, 3'b010);
        chk("rr3_vdout", {24'd0, vid_dout}, 32'h33);
        chk("rr3_cdout_hold", {24'd0, cpu_dout}, 32'h22);
        vid_req = 0; cpu_req = 0;
        tick();

        // Loader arrives while a CPU read waits: no preemption
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h5555;
        tick();
        chk("lc_cpu_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        ldr_req = 1; ldr_addr = 16'h0100; ldr_data = 8'h3C;
        tick();
        chk("lc_no_preempt", {28'd0, mem_we, ldr_ack, vid_ack, cpu_ack}, 32'd0);
        chk("lc_addr_stable", {16'd0, mem_addr}, 32'h5555);
        mem_ready = 1; mem_dout = 8'h5A;
        tick();
        chk("lc_cpu_ack", {29'd0, ldr_ack, vid_ack, cpu_ack}, 32'b001);
        chk("lc_cpu_dout", {24'd0, cpu_dout}, 32'h5A);
        mem_ready = 0; mem_dout = 8'h00;
        tick();
        txn("lc_ldr", 16'h0100, 1'b1, 8'h3C, 8'hC3, 3'b100);
        chk("lc_cdout_hold", {24'd0, cpu_dout}, 32'h5A);
        ldr_req = 0;
        tick();
        txn("lc_cpu2", 16'h5555, 1'b0, 8'h00, 8'h66, 3'b001);
        chk("lc_cpu2_dout", {24'd0, cpu_dout}, 32'h66);
        cpu_req = 0;
        tick();

        // Timeout on a video read
        chk("to_err_pre", {31'd0, err}, 32'd0);
        vid_req = 1; vid_addr = 16'hABCD;
        tick();
        chk("to_rd", {31'd0, mem_rd}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_wait_noack", {29'd0, ldr_ack, vid_ack, cpu_ack}, 32'd0);
        end
        tick();
        chk("to_ack", {29'd0, ldr_ack, vid_ack, cpu_ack}, 32'b010);
        chk("to_dout", {24'd0, vid_dout}, 32'hFF);
        chk("to_err", {31'd0, err}, 32'd1);
        vid_req = 0;
        tick();
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h2000; cpu_din = 8'h99;
        txn("to_cpu_wr", 16'h2000, 1'b1, 8'h99, 8'h00, 3'b001);
        chk("to_err_sticky", {31'd0, err}, 32'd1);
        chk("to_cdout_hold", {24'd0, cpu_dout}, 32'h66);
        cpu_req = 0;
        tick();

        // Reset in WAIT, stray mem_ready afterwards
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4444;
        tick();
        tick();
        RESET = 1'b0; cpu_req = 0;
        tick();
        chk("rw_outs", {26'd0, mem_rd, mem_we, ldr_ack, vid_ack, cpu_ack, err}, 32'd0);
        chk("rw_addr", {16'd0, mem_addr}, 32'd0);
        RESET = 1'b1;
        tick();
        mem_ready = 1; mem_dout = 8'hEE;
        tick();
        chk("rw_stray_noack", {28'd0, mem_rd, ldr_ack, vid_ack, cpu_ack}, 32'd0);
        mem_ready = 0; mem_dout = 8'h00;
        tick();
        chk("rw_dout", {24'd0, cpu_dout}, 32'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4444;
        txn("rw_cpu", 16'h4444, 1'b0, 8'h00, 8'h12, 3'b001);
        chk("rw_cpu_dout", {24'd0, cpu_dout}, 32'h12);
        chk("rw_err", {31'd0, err}, 32'd0);
        cpu_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
